measure_stimulus: RTL and testbench
===================================

# measure_stimulus

Stimulus and sensor front-end for the lag measurement path. It drives the flash patch shown in the video output and aligns each flash to a frame start. It conditions the raw light-sensor line into a single-cycle `sensor_trigger` and issues `reset_counter`/`reset_bcdoutput` to the measure block. It sits between the video timing generator, the sensor pin and `measure`, and closes the loop: flash, detect or time out, go dark, re-arm.

## Interface
- `CYCLES_PER_MS`, 27000: clock cycles per ms tick (27 MHz).
- `FLASH_TIMEOUT_MS`, 500: max ms flash stays on awaiting sensor.
- `DARK_MS`, 250: ms of dark between flashes.
- `DEBOUNCE_CYCLES`, 16: consecutive stable synced samples needed to change debounced level (≥2).
- `clock`  in  1  system clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run measurement loop; low forces IDLE.
- `vsync`  in  1  frame-start level, synchronous to `clock`.
- `sensor_input`  in  1  raw asynchronous light sensor.
- `config_changed`  in  1  one-cycle pulse on configuration change.
- `flash_on`  out  1  high while patch is lit.
- `reset_counter`  out  1  one-cycle pulse at flash start.
- `sensor_trigger`  out  1  one-cycle pulse on debounced rising sensor edge during FLASH.
- `reset_bcdoutput`  out  1  one-cycle pulse, `config_changed` registered.
- `timeout`  out  1  one-cycle pulse when flash expires undetected.
- `measure_count`  out  16  completed measurements, wraps 0xFFFF→0.
- `timeout_count`  out  8  timeouts, saturates at 255.

## Operation
- States: IDLE, ARM, FLASH, DARK. Reset: IDLE, all outputs 0, debounced level 0, counters 0.
- IDLE → ARM when `enable`=1.
- ARM: on the cycle `vsync`=1 with previous sampled `vsync`=0, go to FLASH. `flash_on` and `reset_counter` are registered high on that same edge. `reset_counter` is high for exactly 1 cycle.
- FLASH: `flash_on`=1, ms prescaler starts from 0.
  - Debounced rising edge → `sensor_trigger` pulse, `measure_count`+1, go to DARK.
  - `FLASH_TIMEOUT_MS·CYCLES_PER_MS` cycles in FLASH with no trigger → `timeout` pulse, `timeout_count`+1 (saturating), go to DARK.
- DARK: `flash_on`=0. After `DARK_MS·CYCLES_PER_MS` cycles, go to ARM.
- Sensor path: 2-FF synchronizer, then debounce. The debounced level toggles after `DEBOUNCE_CYCLES` consecutive synced samples differ from it; any agreeing sample clears the run counter. The debouncer runs in every state. A 0→1 debounced transition produces `sensor_trigger` only if the state is FLASH. Transitions in other states are silently dropped. A sensor already high at flash start yields no trigger, so it ends in a timeout.
- Boundary conditions:
  - Trigger and timeout in the same cycle: trigger wins; no `timeout`, no `timeout_count` change.
  - `config_changed` in any state: `reset_bcdoutput` pulses next cycle and both counters clear. In FLASH the flash is aborted to DARK with no trigger and no timeout. If it coincides with a trigger, clear wins and the counters read 0.
  - `enable`=0: next edge goes to IDLE, `flash_on`=0, no pulses. Prescaler and debounce run-counter reset; debounced level kept.
  - `reset_n` low mid-flash: all outputs 0 immediately (asynchronous).

## Timing
- `vsync` rise sampled at edge E: `flash_on`=1 and `reset_counter`=1 after edge E.
- Sensor latency: steady high first sampled by synchronizer at edge N gives `sensor_trigger` high after edge N+2+`DEBOUNCE_CYCLES`. It is registered and lasts exactly 1 cycle. `flash_on` drops on the following edge.
- Count outputs update on the same edge as their pulse.
- `reset_bcdoutput` = `config_changed` delayed 1 cycle.
- Flash-to-flash period ≥ 1 + trigger/timeout time + `DARK_MS·CYCLES_PER_MS` + wait for the next `vsync` rise.

## Test plan
Bench parameters: `CYCLES_PER_MS`=10, `FLASH_TIMEOUT_MS`=5, `DARK_MS`=3, `DEBOUNCE_CYCLES`=4.
- Normal loop: `enable`=1, `vsync` rise, `sensor_input` high 20 cycles after flash start → single `sensor_trigger` 6 edges after first high sample. `measure_count`=1, `flash_on` low next edge, DARK lasts 30 cycles, next flash waits for `vsync` rise.
- Timeout: sensor held low → `timeout` pulse exactly 50 cycles after FLASH entry, `timeout_count`=1. Repeat 300 times → `timeout_count` stays 255.
- Glitch rejection: 3-cycle sensor pulses during FLASH → no trigger. Sensor high during DARK and held → no trigger in the next FLASH, which times out.
- Coincidence: trigger timed to land on cycle 50 of FLASH → `sensor_trigger`=1, `timeout`=0, `timeout_count` unchanged. `config_changed` in the same cycle as a trigger → counters 0, `reset_bcdoutput` next cycle.
- Abort/disable: `config_changed` mid-FLASH → DARK, no pulses. `enable`=0 mid-FLASH → IDLE next edge, `flash_on`=0. `reset_n` low mid-FLASH → all outputs 0 asynchronously, IDLE after release.
- Wrap: preload 65535 measurements (or force) → next trigger gives `measure_count`=0.

Source files
------------

// File: rtl/measure_stimulus.sv
// measure_stimulus: stimulus and light-sensor front-end for the lag measurement path.
// Each flash is aligned to a frame start and the raw sensor line is synchronized and
// debounced. The block pulses reset_counter, sensor_trigger and timeout to the measure
// block and keeps a running count of completed measurements and of timeouts.
module measure_stimulus #(
  parameter int CYCLES_PER_MS    = 27000,
  parameter int FLASH_TIMEOUT_MS = 500,
  parameter int DARK_MS          = 250,
  parameter int DEBOUNCE_CYCLES  = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        vsync,
  input  logic        sensor_input,
  input  logic        config_changed,
  output logic        flash_on,
  output logic        reset_counter,
  output logic        sensor_trigger,
  output logic        reset_bcdoutput,
  output logic        timeout,
  output logic [15:0] measure_count,
  output logic [7:0]  timeout_count
);

  // Counter widths: the ms counter must reach the longer of the two phase lengths.
  localparam int PRE_W  = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
  localparam int MS_MAX = (FLASH_TIMEOUT_MS > DARK_MS) ? FLASH_TIMEOUT_MS : DARK_MS;
  localparam int MS_W   = (MS_MAX > 1) ? $clog2(MS_MAX + 1) : 1;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(CYCLES_PER_MS - 1);
  localparam logic [MS_W-1:0]  FLASH_LAST = MS_W'(FLASH_TIMEOUT_MS - 1);
  localparam logic [MS_W-1:0]  DARK_LAST  = MS_W'(DARK_MS - 1);
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_FLASH = 2'd2,
    S_DARK  = 2'd3
  } state_t;

  // Sensor conditioning
  logic            sync1_q;
  logic            sync2_q;
  logic            level_q;
  logic            level_d;
  logic            level_prev_q;
  logic [DB_W-1:0] run_q;
  logic [DB_W-1:0] run_d;
  logic            level_rise;

  // Sequencer
  state_t          state_q;
  logic            vsync_prev_q;
  logic [PRE_W-1:0] pre_q;
  logic [MS_W-1:0] ms_q;
  logic            ms_tick;
  logic            flash_expired;
  logic            dark_expired;
  logic            vsync_rise;

  // Registered outputs
  logic            flash_on_q;
  logic            reset_counter_q;
  logic            sensor_trigger_q;
  logic            reset_bcdoutput_q;
  logic            timeout_q;
  logic [15:0]     measure_count_q;
  logic [7:0]      timeout_count_q;

  // Debounce next-state: the level flips only after DEBOUNCE_CYCLES consecutive
  // disagreeing samples; one agreeing sample restarts the run. Disable freezes it.
  always_comb begin
    level_d = level_q;
    run_d   = run_q;
    if (!enable) begin
      run_d = '0;
    end else if (sync2_q == level_q) begin
      run_d = '0;
    end else if (run_q == DB_LAST) begin
      level_d = sync2_q;
      run_d   = '0;
    end else begin
      run_d = run_q + 1'b1;
    end
  end

  // Two-flop synchronizer, debounce state and previous debounced level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      run_q        <= '0;
    end else begin
      sync1_q      <= sensor_input;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      run_q        <= run_d;
    end
  end

  // A rise is seen one cycle after the debounced level flips, which makes the
  // trigger land DEBOUNCE_CYCLES+2 edges after the synchronizer first sees it.
  assign level_rise    = level_q & ~level_prev_q;
  assign vsync_rise    = vsync & ~vsync_prev_q;
  assign ms_tick       = (pre_q == PRE_LAST);
  assign flash_expired = ms_tick && (ms_q == FLASH_LAST);
  assign dark_expired  = ms_tick && (ms_q == DARK_LAST);

  // Measurement sequencer: IDLE -> ARM -> FLASH -> DARK -> ARM, with counters and pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= S_IDLE;
      vsync_prev_q      <= 1'b0;
      pre_q             <= '0;
      ms_q              <= '0;
      flash_on_q        <= 1'b0;
      reset_counter_q   <= 1'b0;
      sensor_trigger_q  <= 1'b0;
      reset_bcdoutput_q <= 1'b0;
      timeout_q         <= 1'b0;
      measure_count_q   <= '0;
      timeout_count_q   <= '0;
    end else begin
      vsync_prev_q      <= vsync;
      reset_counter_q   <= 1'b0;
      sensor_trigger_q  <= 1'b0;
      timeout_q         <= 1'b0;
      reset_bcdoutput_q <= config_changed;

      // ms prescaler advances every cycle; phases that do not time anything
      // hold it at zero and every phase entry restarts it.
      if (ms_tick) begin
        pre_q <= '0;
        ms_q  <= ms_q + 1'b1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end

      if (!enable) begin
        state_q    <= S_IDLE;
        flash_on_q <= 1'b0;
        pre_q      <= '0;
        ms_q       <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q <= S_ARM;
            pre_q   <= '0;
            ms_q    <= '0;
          end

          S_ARM: begin
            pre_q <= '0;
            ms_q  <= '0;
            if (vsync_rise) begin
              state_q         <= S_FLASH;
              flash_on_q      <= 1'b1;
              reset_counter_q <= 1'b1;
            end
          end

          S_FLASH: begin
            // A configuration change aborts the flash silently; a detection
            // beats a simultaneous expiry.
            if (config_changed) begin
              state_q <= S_DARK;
              pre_q   <= '0;
              ms_q    <= '0;
            end else if (level_rise) begin
              state_q          <= S_DARK;
              sensor_trigger_q <= 1'b1;
              measure_count_q  <= measure_count_q + 1'b1;
              pre_q            <= '0;
              ms_q             <= '0;
            end else if (flash_expired) begin
              state_q   <= S_DARK;
              timeout_q <= 1'b1;
              if (timeout_count_q != 8'hFF) begin
                timeout_count_q <= timeout_count_q + 1'b1;
              end
              pre_q <= '0;
              ms_q  <= '0;
            end
          end

          S_DARK: begin
            // The patch goes dark on the edge after the flash ends.
            flash_on_q <= 1'b0;
            if (dark_expired) begin
              state_q <= S_ARM;
              pre_q   <= '0;
              ms_q    <= '0;
            end
          end

          default: begin
            state_q    <= S_IDLE;
            flash_on_q <= 1'b0;
            pre_q      <= '0;
            ms_q       <= '0;
          end
        endcase
      end

      // Clearing the counters overrides any increment on the same edge.
      if (config_changed) begin
        measure_count_q <= '0;
        timeout_count_q <= '0;
      end
    end
  end

  assign flash_on        = flash_on_q;
  assign reset_counter   = reset_counter_q;
  assign sensor_trigger  = sensor_trigger_q;
  assign reset_bcdoutput = reset_bcdoutput_q;
  assign timeout         = timeout_q;
  assign measure_count   = measure_count_q;
  assign timeout_count   = timeout_count_q;

endmodule

// File: tb/tb_measure_stimulus.sv
// tb_measure_stimulus: directed scenarios for measure_stimulus with small timing
// parameters (10 cycles/ms, 5 ms flash timeout, 3 ms dark, 4-sample debounce).
module tb_measure_stimulus;

  localparam int CPM = 10;
  localparam int TO  = 5;
  localparam int DK  = 3;
  localparam int DB  = 4;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic        vsync;
  logic        sensor_input;
  logic        config_changed;
  logic        flash_on;
  logic        reset_counter;
  logic        sensor_trigger;
  logic        reset_bcdoutput;
  logic        timeout;
  logic [15:0] measure_count;
  logic [7:0]  timeout_count;

  int checks = 0;
  int passes = 0;
  int trig_cnt = 0;
  int to_cnt = 0;

  measure_stimulus #(
    .CYCLES_PER_MS(CPM),
    .FLASH_TIMEOUT_MS(TO),
    .DARK_MS(DK),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .enable(enable),
    .vsync(vsync),
    .sensor_input(sensor_input),
    .config_changed(config_changed),
    .flash_on(flash_on),
    .reset_counter(reset_counter),
    .sensor_trigger(sensor_trigger),
    .reset_bcdoutput(reset_bcdoutput),
    .timeout(timeout),
    .measure_count(measure_count),
    .timeout_count(timeout_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse tallies taken on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (sensor_trigger === 1'b1) trig_cnt <= trig_cnt + 1;
    if (timeout === 1'b1) to_cnt <= to_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset;
    config_changed = 1'b1;
    step(2);
    checks++;
    if ({flash_on, reset_counter, sensor_trigger, reset_bcdoutput, timeout} !== 5'b0)
      $display("FAIL reset_pulses: got %b want 00000",
               {flash_on, reset_counter, sensor_trigger, reset_bcdoutput, timeout});
    else passes++;
    checks++;
    if ({measure_count, timeout_count} !== 24'h0)
      $display("FAIL reset_counts: got %h/%h want 0000/00", measure_count, timeout_count);
    else passes++;
    config_changed = 1'b0;
    reset_n = 1'b1;
    step(2);
    checks++;
    if ({flash_on, reset_counter} !== 2'b00)
      $display("FAIL reset_disabled_idle: got %b want 00", {flash_on, reset_counter});
    else passes++;
  endtask

  task automatic test_normal;
    int tr0;
    tr0 = trig_cnt;
    enable = 1'b1;
    step(2);
    vsync = 1'b1;
    step(1);                                  // edge E
    checks++;
    if ({flash_on, reset_counter} !== 2'b11)
      $display("FAIL norm_flash_start: got %b want 11", {flash_on, reset_counter});
    else passes++;
    vsync = 1'b0;
    step(1);                                  // E+1
    checks++;
    if ({flash_on, reset_counter} !== 2'b10)
      $display("FAIL norm_rc_one_cycle: got %b want 10", {flash_on, reset_counter});
    else passes++;
    step(18);                                 // E+19
    sensor_input = 1'b1;                      // first sampled at E+20
    step(6);                                  // E+25
    checks++;
    if (sensor_trigger !== 1'b0)
      $display("FAIL norm_trig_early: got %b want 0", sensor_trigger);
    else passes++;
    step(1);                                  // E+26 = T
    checks++;
    if ({sensor_trigger, flash_on, timeout} !== 3'b110 || measure_count !== 16'd1)
      $display("FAIL norm_trigger: got trig/flash/to %b count %0d want 110 count 1",
               {sensor_trigger, flash_on, timeout}, measure_count);
    else passes++;
    step(1);                                  // T+1
    checks++;
    if ({sensor_trigger, flash_on} !== 2'b00)
      $display("FAIL norm_dark_next: got %b want 00", {sensor_trigger, flash_on});
    else passes++;
    sensor_input = 1'b0;
    step(28);                                 // T+29
    vsync = 1'b1;
    step(1);                                  // T+30: still DARK on this edge
    checks++;
    if ({flash_on, reset_counter} !== 2'b00)
      $display("FAIL norm_dark_hold: got %b want 00", {flash_on, reset_counter});
    else passes++;
    vsync = 1'b0;
    step(1);                                  // T+31
    vsync = 1'b1;
    step(1);                                  // T+32
    checks++;
    if ({flash_on, reset_counter} !== 2'b11)
      $display("FAIL norm_rearm_flash: got %b want 11", {flash_on, reset_counter});
    else passes++;
    vsync = 1'b0;
    checks++;
    if (trig_cnt - tr0 !== 1)
      $display("FAIL norm_single_trigger: got %0d pulses want 1", trig_cnt - tr0);
    else passes++;
  endtask

  task automatic test_timeout;
    step(49);                                 // F+49
    checks++;
    if ({timeout, flash_on} !== 2'b01)
      $display("FAIL to_early: got %b want 01", {timeout, flash_on});
    else passes++;
    step(1);                                  // F+50
    checks++;
    if ({timeout, sensor_trigger} !== 2'b10 || timeout_count !== 8'd1 || measure_count !== 16'd1)
      $display("FAIL to_pulse: got to/trig %b tcount %0d mcount %0d want 10 1 1",
               {timeout, sensor_trigger}, timeout_count, measure_count);
    else passes++;
    step(1);                                  // F+51
    checks++;
    if ({timeout, flash_on} !== 2'b00)
      $display("FAIL to_after: got %b want 00", {timeout, flash_on});
    else passes++;
    step(29);                                 // F+80: DARK ends on this edge
    vsync = 1'b1;
    step(1);                                  // F+81
    checks++;
    if (flash_on !== 1'b1)
      $display("FAIL to_dark_exact_30: got flash_on %b want 1", flash_on);
    else passes++;
    vsync = 1'b0;
  endtask

  task automatic test_saturate;
    int to0;
    int n;
    to0 = to_cnt;
    for (int i = 0; i < 300; i++) begin
      n = 0;
      while (timeout !== 1'b1 && n < 60) begin
        step(1);
        n++;
      end
      if (n >= 60) begin
        checks++;
        $display("FAIL sat_wait: no timeout within 60 cycles at iteration %0d", i);
        break;
      end
      if (i == 252) begin
        checks++;
        if (timeout_count !== 8'd254)
          $display("FAIL sat_254: got %0d want 254", timeout_count);
        else passes++;
      end
      step(31);
      vsync = 1'b1;
      step(1);
      vsync = 1'b0;
    end
    checks++;
    if (timeout_count !== 8'd255)
      $display("FAIL sat_255: got %0d want 255", timeout_count);
    else passes++;
    checks++;
    if (to_cnt - to0 !== 300)
      $display("FAIL sat_pulses: got %0d pulses want 300", to_cnt - to0);
    else passes++;
  endtask

  task automatic test_glitch;
    int tr0;
    tr0 = trig_cnt;
    repeat (5) begin
      sensor_input = 1'b1;
      step(3);
      sensor_input = 1'b0;
      step(3);
    end                                       // H+30
    step(20);                                 // H+50
    checks++;
    if (timeout !== 1'b1 || trig_cnt - tr0 !== 0 || measure_count !== 16'd1)
      $display("FAIL glitch_reject: got to %b trig %0d mcount %0d want 1 0 1",
               timeout, trig_cnt - tr0, measure_count);
    else passes++;
  endtask

  task automatic test_held_high;
    int tr0;
    tr0 = trig_cnt;
    step(2);                                  // H+52, in DARK
    sensor_input = 1'b1;
    step(28);                                 // H+80
    vsync = 1'b1;
    step(1);                                  // J
    vsync = 1'b0;
    checks++;
    if (flash_on !== 1'b1)
      $display("FAIL held_flash: got %b want 1", flash_on);
    else passes++;
    step(49);                                 // J+49
    checks++;
    if (timeout !== 1'b0)
      $display("FAIL held_to_early: got %b want 0", timeout);
    else passes++;
    step(1);                                  // J+50
    checks++;
    if (timeout !== 1'b1 || trig_cnt - tr0 !== 0)
      $display("FAIL held_timeout: got to %b trig %0d want 1 0", timeout, trig_cnt - tr0);
    else passes++;
    sensor_input = 1'b0;
  endtask

  task automatic test_config_trigger;
    step(31);                                 // ARM
    vsync = 1'b1;
    step(1);                                  // L
    vsync = 1'b0;
    step(9);                                  // L+9
    sensor_input = 1'b1;                      // trigger would land on L+16
    step(6);                                  // L+15
    config_changed = 1'b1;
    step(1);                                  // L+16
    checks++;
    if (measure_count !== 16'd0 || timeout_count !== 8'd0 || reset_bcdoutput !== 1'b1)
      $display("FAIL cfgtrig_clear: got mcount %0d tcount %0d bcd %b want 0 0 1",
               measure_count, timeout_count, reset_bcdoutput);
    else passes++;
    config_changed = 1'b0;
    step(1);                                  // L+17
    checks++;
    if ({reset_bcdoutput, flash_on} !== 2'b00 || measure_count !== 16'd0)
      $display("FAIL cfgtrig_after: got bcd/flash %b mcount %0d want 00 0",
               {reset_bcdoutput, flash_on}, measure_count);
    else passes++;
    sensor_input = 1'b0;
  endtask

  task automatic test_coincide;
    step(30);                                 // ARM
    vsync = 1'b1;
    step(1);                                  // M
    vsync = 1'b0;
    step(43);                                 // M+43
    sensor_input = 1'b1;                      // trigger lands on M+50
    step(6);                                  // M+49
    checks++;
    if ({sensor_trigger, timeout} !== 2'b00)
      $display("FAIL coinc_early: got %b want 00", {sensor_trigger, timeout});
    else passes++;
    step(1);                                  // M+50
    checks++;
    if ({sensor_trigger, timeout} !== 2'b10)
      $display("FAIL coinc_trig_wins: got trig/to %b want 10", {sensor_trigger, timeout});
    else passes++;
    checks++;
    if (timeout_count !== 8'd0 || measure_count !== 16'd1)
      $display("FAIL coinc_counts: got tcount %0d mcount %0d want 0 1",
               timeout_count, measure_count);
    else passes++;
    step(1);                                  // M+51
    checks++;
    if ({timeout, flash_on} !== 2'b00)
      $display("FAIL coinc_after: got %b want 00", {timeout, flash_on});
    else passes++;
    sensor_input = 1'b0;
  endtask

  task automatic test_abort_config;
    int tr0;
    int to0;
    step(30);                                 // ARM
    vsync = 1'b1;
    step(1);                                  // P
    vsync = 1'b0;
    step(10);                                 // P+10
    tr0 = trig_cnt;
    to0 = to_cnt;
    config_changed = 1'b1;
    step(1);                                  // P+11
    checks++;
    if (reset_bcdoutput !== 1'b1 || measure_count !== 16'd0 || {sensor_trigger, timeout} !== 2'b00)
      $display("FAIL abort_cfg: got bcd %b mcount %0d trig/to %b want 1 0 00",
               reset_bcdoutput, measure_count, {sensor_trigger, timeout});
    else passes++;
    config_changed = 1'b0;
    step(1);                                  // P+12
    checks++;
    if ({flash_on, reset_bcdoutput} !== 2'b00)
      $display("FAIL abort_dark: got flash/bcd %b want 00", {flash_on, reset_bcdoutput});
    else passes++;
    step(45);
    checks++;
    if (to_cnt - to0 !== 0 || trig_cnt - tr0 !== 0 || flash_on !== 1'b0)
      $display("FAIL abort_quiet: got to %0d trig %0d flash %b want 0 0 0",
               to_cnt - to0, trig_cnt - tr0, flash_on);
    else passes++;
  endtask

  task automatic test_disable;
    int to0;
    vsync = 1'b1;
    step(1);                                  // Q
    vsync = 1'b0;
    step(5);
    enable = 1'b0;
    to0 = to_cnt;
    step(1);
    checks++;
    if (flash_on !== 1'b0)
      $display("FAIL dis_flash_off: got %b want 0", flash_on);
    else passes++;
    step(50);
    vsync = 1'b1;
    step(1);
    checks++;
    if ({flash_on, reset_counter} !== 2'b00 || to_cnt - to0 !== 0)
      $display("FAIL dis_idle: got flash/rc %b timeouts %0d want 00 0",
               {flash_on, reset_counter}, to_cnt - to0);
    else passes++;
    vsync = 1'b0;
    step(1);
    enable = 1'b1;
    step(1);                                  // IDLE -> ARM
    vsync = 1'b1;
    step(1);                                  // R
    vsync = 1'b0;
    checks++;
    if ({flash_on, reset_counter} !== 2'b11)
      $display("FAIL dis_reenable: got %b want 11", {flash_on, reset_counter});
    else passes++;
  endtask

  task automatic test_async_reset;
    step(50);                                 // R+50
    checks++;
    if (timeout !== 1'b1 || timeout_count !== 8'd1)
      $display("FAIL ares_setup: got to %b tcount %0d want 1 1", timeout, timeout_count);
    else passes++;
    step(30);
    vsync = 1'b1;
    step(1);                                  // S
    vsync = 1'b0;
    step(10);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({flash_on, reset_counter, sensor_trigger, reset_bcdoutput, timeout,
         measure_count, timeout_count} !== 29'd0)
      $display("FAIL ares_async_clear: got flash %b tcount %0d mcount %0d want all 0",
               flash_on, timeout_count, measure_count);
    else passes++;
    step(2);
    reset_n = 1'b1;
    vsync = 1'b1;
    step(1);                                  // IDLE -> ARM, no flash
    checks++;
    if ({flash_on, reset_counter} !== 2'b00)
      $display("FAIL ares_idle_first: got %b want 00", {flash_on, reset_counter});
    else passes++;
    vsync = 1'b0;
    step(1);
    vsync = 1'b1;
    step(1);                                  // W
    vsync = 1'b0;
    checks++;
    if ({flash_on, reset_counter} !== 2'b11)
      $display("FAIL ares_rearm: got %b want 11", {flash_on, reset_counter});
    else passes++;
  endtask

  task automatic test_wrap;
    dut.measure_count_q = 16'hFFFF;
    sensor_input = 1'b1;                      // first sampled at W+1
    step(6);                                  // W+6
    checks++;
    if (sensor_trigger !== 1'b0)
      $display("FAIL wrap_early: got %b want 0", sensor_trigger);
    else passes++;
    step(1);                                  // W+7
    checks++;
    if (sensor_trigger !== 1'b1 || measure_count !== 16'h0000)
      $display("FAIL wrap_count: got trig %b mcount %h want 1 0000",
               sensor_trigger, measure_count);
    else passes++;
    sensor_input = 1'b0;
    step(2);
  endtask

  initial begin
    reset_n        = 1'b1;
    enable         = 1'b0;
    vsync          = 1'b0;
    sensor_input   = 1'b0;
    config_changed = 1'b0;
    #2;
    reset_n = 1'b0;
    test_reset;
    test_normal;
    test_timeout;
    test_saturate;
    test_glitch;
    test_held_high;
    test_config_trigger;
    test_coincide;
    test_abort_config;
    test_disable;
    test_async_reset;
    test_wrap;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
